// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and ALU signals shared by the arbiter and its neighbours
interface alu_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int MODE_W = 4,
   parameter int RES_W  = 16
);
   logic              req0, req1;
   logic [DATA_W-1:0] a0, b0, a1, b1;
   logic [MODE_W-1:0] mode0, mode1;
   logic              ack0, ack1, rvalid0, rvalid1;
   logic [RES_W-1:0]  res0, res1;
   logic [DATA_W-1:0] alu_a, alu_b;
   logic [MODE_W-1:0] alu_mode;
   logic              alu_start;
   logic [RES_W-1:0]  alu_result;
   logic              busy;
   logic [1:0]        arb_state;
   modport master (
      output req0, a0, b0, mode0, req1, a1, b1, mode1, alu_result,
      input  ack0, ack1, rvalid0, rvalid1, res0, res1, alu_a, alu_b, alu_mode,
             alu_start, busy, arb_state
   );
   modport slave (
      input  req0, a0, b0, mode0, req1, a1, b1, mode1, alu_result,
      output ack0, ack1, rvalid0, rvalid1, res0, res1, alu_a, alu_b, alu_mode,
             alu_start, busy, arb_state
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one multi-cycle ALU between two requesters
module alu_arbiter #(
   parameter int DATA_W  = 8,
   parameter int MODE_W  = 4,
   parameter int RES_W   = 16,
   parameter int ALU_LAT = 2
) (
   input logic         i_clk,
   input logic         i_rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESPOND = 2'd3;
   logic [1:0]        r_state;
   logic              r_owner, r_last;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_alu_a, r_alu_b;
   logic [MODE_W-1:0] r_alu_mode;
   logic [RES_W-1:0]  r_res0, r_res1;
   logic              w_any, w_gnt;
   // with both requests pending, the one not served last wins
   assign w_any = bus.req0 | bus.req1;
   assign w_gnt = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_cnt      <= 4'd0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_mode <= '0;
         r_res0     <= '0;
         r_res1     <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_state    <= ISSUE;
               r_owner    <= w_gnt;
               r_last     <= w_gnt;
               r_cnt      <= 4'(ALU_LAT);
               r_alu_a    <= w_gnt ? bus.a1 : bus.a0;
               r_alu_b    <= w_gnt ? bus.b1 : bus.b0;
               r_alu_mode <= w_gnt ? bus.mode1 : bus.mode0;
            end
            ISSUE: r_state <= WAIT;
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= RESPOND;
                  if (r_owner) r_res1 <= bus.alu_result;
                  else r_res0 <= bus.alu_result;
               end
            end
            RESPOND: r_state <= IDLE;
         endcase
      end
   end
   // strobes decode from registered state only
   assign bus.alu_start = r_state == ISSUE;
   assign bus.ack0      = r_state == ISSUE && !r_owner;
   assign bus.ack1      = r_state == ISSUE && r_owner;
   assign bus.rvalid0   = r_state == RESPOND && !r_owner;
   assign bus.rvalid1   = r_state == RESPOND && r_owner;
   assign bus.busy      = r_state != IDLE;
   assign bus.arb_state = r_state;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_mode  = r_alu_mode;
   assign bus.res0      = r_res0;
   assign bus.res1      = r_res1;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of grant order, latency, operand hold and reset
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] tick_cnt = 16'd0;
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) tick_cnt <= tick_cnt + 16'd1;
   alu_arbiter_if #(.DATA_W(8), .MODE_W(4), .RES_W(16)) bus ();
   alu_arbiter_if #(.DATA_W(8), .MODE_W(4), .RES_W(16)) bus5 ();
   alu_arbiter #(.ALU_LAT(2)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
   alu_arbiter #(.ALU_LAT(5)) dut5 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus5.slave));
   // adder ALU for the main instance, time-varying ALU for the latency instance
   assign bus.alu_result  = {8'h00, bus.alu_a} + {8'h00, bus.alu_b};
   assign bus5.alu_result = tick_cnt;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      checks++; if (bus.arb_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.arb_state); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.res0 !== 16'd0 || bus.res1 !== 16'd0) begin errors++; $display("FAIL reset_res got %h/%h want 0/0", bus.res0, bus.res1); end
      checks++; if ({bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.alu_start} !== 5'd0) begin errors++; $display("FAIL reset_strobes got %b want 00000", {bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.alu_start}); end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alu_mode} !== 20'd0) begin errors++; $display("FAIL reset_alu_regs got %h want 0", {bus.alu_a, bus.alu_b, bus.alu_mode}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single;
      bus.a0 = 8'h12; bus.b0 = 8'h34; bus.mode0 = 4'h1; bus.req0 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      checks++; if (bus.ack0 !== 1'b1 || bus.alu_start !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL single_ack got ack0=%b start=%b ack1=%b want 1 1 0", bus.ack0, bus.alu_start, bus.ack1); end
      checks++; if (bus.arb_state !== 2'd1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_issue_state got %0d busy=%b want 1 busy=1", bus.arb_state, bus.busy); end
      checks++; if (bus.alu_a !== 8'h12 || bus.alu_b !== 8'h34 || bus.alu_mode !== 4'h1) begin errors++; $display("FAIL single_operands got %h %h %h want 12 34 1", bus.alu_a, bus.alu_b, bus.alu_mode); end
      tick();
      checks++; if (bus.arb_state !== 2'd2 || bus.ack0 !== 1'b0 || bus.alu_start !== 1'b0) begin errors++; $display("FAIL single_wait got state=%0d ack0=%b start=%b want 2 0 0", bus.arb_state, bus.ack0, bus.alu_start); end
      tick();
      checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got %b want 0", bus.rvalid0); end
      tick();
      checks++; if (bus.rvalid0 !== 1'b1 || bus.res0 !== 16'h0046) begin errors++; $display("FAIL single_result got rvalid0=%b res0=%h want 1 0046", bus.rvalid0, bus.res0); end
      checks++; if (bus.rvalid1 !== 1'b0 || bus.res1 !== 16'h0000 || bus.arb_state !== 2'd3) begin errors++; $display("FAIL single_other got rvalid1=%b res1=%h state=%0d want 0 0000 3", bus.rvalid1, bus.res1, bus.arb_state); end
      tick();
      checks++; if (bus.rvalid0 !== 1'b0 || bus.busy !== 1'b0 || bus.res0 !== 16'h0046) begin errors++; $display("FAIL single_idle got rvalid0=%b busy=%b res0=%h want 0 0 0046", bus.rvalid0, bus.busy, bus.res0); end
   endtask

   task automatic test_contest;
      int  n;
      bit  found, got_rv0, got_rv1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus.a0 = 8'd3; bus.b0 = 8'd4; bus.a1 = 8'd10; bus.b1 = 8'd20;
      bus.mode0 = 4'h1; bus.mode1 = 4'h1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL contest_first got ack0=%b ack1=%b want 1 0", bus.ack0, bus.ack1); end
      n = 0; found = 0; got_rv0 = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         n++;
         if (bus.rvalid0) begin
            got_rv0 = 1;
            checks++; if (bus.res0 !== 16'd7) begin errors++; $display("FAIL contest_res0 got %0d want 7", bus.res0); end
         end
         if (bus.ack1) found = 1;
      end
      bus.req1 = 1'b0;
      checks++; if (!found || n != 5 || !got_rv0) begin errors++; $display("FAIL contest_spacing got found=%0d gap=%0d rv0=%0d want 1 5 1", found, n, got_rv0); end
      got_rv1 = 0;
      for (int i = 0; i < 8 && !got_rv1; i++) begin
         tick();
         if (bus.rvalid1) got_rv1 = 1;
      end
      checks++; if (!got_rv1 || bus.res1 !== 16'd30 || bus.res0 !== 16'd7) begin errors++; $display("FAIL contest_res1 got rv1=%0d res1=%0d res0=%0d want 1 30 7", got_rv1, bus.res1, bus.res0); end
      tick();
   endtask

   task automatic test_fairness;
      int  g;
      int  grants[6];
      bit  both;
      g = 0; both = 0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int i = 0; i < 60 && g < 6; i++) begin
         tick();
         if (bus.ack0 && bus.ack1) both = 1;
         if (bus.ack0 || bus.ack1) begin
            grants[g] = bus.ack1 ? 1 : 0;
            g++;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      checks++; if (g != 6 || both) begin errors++; $display("FAIL fair_count got grants=%0d both=%0d want 6 0", g, both); end
      for (int i = 0; i < g; i++) begin
         checks++; if (grants[i] != i % 2) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", i, grants[i], i % 2); end
      end
      for (int i = 0; i < 10 && bus.busy; i++) tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fair_drain got busy=%b want 0", bus.busy); end
   endtask

   task automatic test_operand_hold;
      bus.a0 = 8'h12; bus.b0 = 8'h34; bus.req0 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      checks++; if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL hold_ack got %b want 1", bus.ack0); end
      bus.a0 = 8'hFF;
      tick();
      checks++; if (bus.alu_a !== 8'h12) begin errors++; $display("FAIL hold_wait1 got %h want 12", bus.alu_a); end
      tick();
      checks++; if (bus.alu_a !== 8'h12 || bus.arb_state !== 2'd2) begin errors++; $display("FAIL hold_wait2 got a=%h state=%0d want 12 2", bus.alu_a, bus.arb_state); end
      tick();
      checks++; if (bus.rvalid0 !== 1'b1 || bus.res0 !== 16'h0046) begin errors++; $display("FAIL hold_result got rvalid0=%b res0=%h want 1 0046", bus.rvalid0, bus.res0); end
      tick();
   endtask

   task automatic test_reset_mid;
      bit seen;
      bus.a0 = 8'd1; bus.b0 = 8'd2; bus.req0 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      tick();
      checks++; if (bus.arb_state !== 2'd2) begin errors++; $display("FAIL mid_in_wait got %0d want 2", bus.arb_state); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.arb_state !== 2'd0 || bus.busy !== 1'b0 || bus.res0 !== 16'd0 || bus.alu_start !== 1'b0) begin errors++; $display("FAIL mid_async got state=%0d busy=%b res0=%h start=%b want 0 0 0 0", bus.arb_state, bus.busy, bus.res0, bus.alu_start); end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.rvalid0 || bus.ack0) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("FAIL mid_ghost got rvalid0/ack0 after reset want none"); end
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      checks++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL mid_regrant got ack0=%b ack1=%b want 1 0", bus.ack0, bus.ack1); end
      for (int i = 0; i < 10 && !bus.ack1; i++) tick();
      bus.req1 = 1'b0;
      for (int i = 0; i < 10 && bus.busy; i++) tick();
   endtask

   task automatic test_latency;
      logic [15:0] exp;
      int          n;
      bit          got;
      bus5.a0 = 8'h5A; bus5.b0 = 8'h01; bus5.mode0 = 4'h2; bus5.req0 = 1'b1;
      tick();
      bus5.req0 = 1'b0;
      checks++; if (bus5.alu_start !== 1'b1) begin errors++; $display("FAIL lat_start got %b want 1", bus5.alu_start); end
      exp = tick_cnt + 16'd5;
      n = 0; got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         n++;
         if (bus5.rvalid0) got = 1;
      end
      checks++; if (!got || n != 6) begin errors++; $display("FAIL lat_rvalid got seen=%0d after=%0d want 1 6", got, n); end
      checks++; if (bus5.res0 !== exp) begin errors++; $display("FAIL lat_res0 got %h want %h", bus5.res0, exp); end
      tick();
   endtask

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0; bus.mode0 = '0; bus.mode1 = '0;
      bus5.req0 = 1'b0; bus5.req1 = 1'b0;
      bus5.a0 = '0; bus5.b0 = '0; bus5.a1 = '0; bus5.b1 = '0; bus5.mode0 = '0; bus5.mode1 = '0;
      test_reset();
      test_single();
      test_contest();
      test_fairness();
      test_operand_hold();
      test_reset_mid();
      test_latency();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one calculator ALU between two instruction-stream controllers (requester 0, requester 1).
- Grants requesters round-robin and latches the granted operands and mode.
- Drives the ALU, waits a fixed ALU latency, then returns the result to the owner with a one-cycle valid pulse.
- Sits between the calculator controllers and the ALU, replacing the direct controller-to-ALU A/B/Mode connection.

Parameters:
- DATA_W, 8, operand width (A, B).
- MODE_W, 4, ALU mode/opcode width.
- RES_W, 16, ALU result width.
- ALU_LAT, 2, cycles from the ALU start cycle to a valid alu_result; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 operation request (level).
- a0  in  DATA_W  requester 0 operand A.
- b0  in  DATA_W  requester 0 operand B.
- mode0  in  MODE_W  requester 0 ALU mode.
- ack0  out  1  one-cycle pulse: requester 0 operands captured.
- rvalid0  out  1  one-cycle pulse: res0 holds a new result.
- res0  out  RES_W  requester 0 result; held until the next rvalid0.
- req1, a1, b1, mode1, ack1, rvalid1, res1: same as requester 0, for requester 1.
- alu_a  out  DATA_W  latched operand A to the ALU.
- alu_b  out  DATA_W  latched operand B to the ALU.
- alu_mode  out  MODE_W  latched mode to the ALU.
- alu_start  out  1  one-cycle start strobe to the ALU.
- alu_result  in  RES_W  ALU output.
- busy  out  1  high in every state except IDLE.
- arb_state  out  2  debug: IDLE=0, ISSUE=1, WAIT=2, RESPOND=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including res0, res1, alu_a, alu_b, alu_mode.
  - Internal last_grant=1, so requester 0 wins the first contest.
  - Latency counter = 0.
  - An in-flight operation is discarded: no rvalid, no ack.
- Registers: all outputs are registered; none is a combinational function of req inputs.
- IDLE:
  - req inputs are sampled only in IDLE.
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On the grant edge:
    - Capture the owner's a/b/mode into alu_a/alu_b/alu_mode.
    - Set owner and last_grant to the granted requester.
    - Load the counter with ALU_LAT.
    - Go to ISSUE.
- ISSUE (1 cycle):
  - alu_start=1.
  - ack of the owner = 1; the other ack = 0.
  - Go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - alu_a/b/mode stay stable through WAIT.
  - In the cycle the counter reads 1, sample alu_result into the owner's res register at the closing edge and go to RESPOND.
  - WAIT therefore lasts exactly ALU_LAT cycles.
- RESPOND (1 cycle):
  - rvalid of the owner = 1.
  - Go to IDLE.
  - The non-owner's res is untouched.
- Latency: req sampled in cycle t gives ack in cycle t+1 and rvalid in cycle t+ALU_LAT+2.
- Throughput: the next grant's ISSUE cycle is at earliest t+ALU_LAT+4. No pipelining; one operation in flight.
- Requester rules:
  - Operands and mode must be valid while req is high in an IDLE cycle; they may change after ack.
  - The requester drops req by the edge closing its ack cycle.
  - req still high when the arbiter re-enters IDLE is a new request.
  - req changes outside IDLE are ignored; there is no cancel.
- Starvation-free: with both reqs held high continuously, grants strictly alternate.
- Simultaneous events: rvalid of one requester and the other requester's req rising in the same cycle is legal; that req is sampled in the following IDLE cycle.
- Width rules: no arithmetic on data; alu_result is passed to res unmodified, at full RES_W.

Test Plan:
- Single request, ALU_LAT=2: a0=8'h12, b0=8'h34, mode0=4'h1, req0 held 1 cycle in IDLE, ALU model alu_result=a+b=16'h0046 → ack0 exactly 1 cycle later, alu_start same cycle, rvalid0 4 cycles after sampling with res0=16'h0046; res1, ack1, rvalid1 stay 0.
- Contest after reset: req0 and req1 high together with a0=3, b0=4, a1=10, b1=20, mode=add → requester 0 granted first (res0=7); then requester 1 (res1=30); ack0 and ack1 ISSUE cycles separated by ALU_LAT+3=5 cycles.
- Fairness: both reqs held high for 6 operations → grant order 0,1,0,1,0,1; no back-to-back grant to the same requester.
- Operand change after ack: a0 changes to 8'hFF the cycle after ack0 → alu_a holds the original 8'h12 through WAIT; res0 reflects the original operands.
- Reset mid-operation: reset low during WAIT → immediately arb_state=0, busy=0, res0=0, alu_start=0; no rvalid0 after reset release; next contest grants requester 0.
- Latency parameter: ALU_LAT=5 with alu_result changing every cycle → res0 equals the value alu_result had exactly 5 cycles after the alu_start cycle.
